// File: rtl/rs170_pkg.sv
// Shared definitions for the RS170 interlaced timing controller: lock-state
// encoding, default raster constants and a span helper for parameterised builds.
package rs170_pkg;

    typedef enum logic [1:0] {
        UNLOCKED    = 2'd0,
        WAIT_ORIGIN = 2'd1,
        LOCKED      = 2'd2
    } lock_state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 240;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 16;

    localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL0 = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int V_TOTAL1 = V_TOTAL0 + 1;

    localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int HS_END   = HS_START + DEF_H_SYNC;
    localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int VS_END   = VS_START + DEF_V_SYNC;

    function automatic int span(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/rs170_raster_cnt.sv
// Horizontal/vertical/field counters with region decode for the RS170 raster.
// With RS170_TEST_PATTERN_EN defined it also reports the colour-bar index.
module rs170_raster_cnt
    import rs170_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HW       = 10,
    parameter int VW       = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       field,
    output logic       active,
    output logic       origin,
    output logic       hsync,
    output logic       vsync
`ifdef RS170_TEST_PATTERN_EN
    ,
    output logic [2:0] bar
`endif
);

    localparam int LINE_LEN = span(H_ACTIVE, H_FP, H_SYNC, H_BP);

    localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_LO  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_HI  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_HALF = HW'(LINE_LEN / 2);

    localparam logic [VW-1:0] V_LAST0 = VW'(span(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [VW-1:0] V_LAST1 = VW'(span(V_ACTIVE, V_FP, V_SYNC, V_BP + 1) - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_LO   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_HI   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == (field ? V_LAST1 : V_LAST0));

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
            field <= 1'b0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            if (v_wrap) begin
                v_cnt <= '0;
                field <= ~field;
            end else begin
                v_cnt <= v_cnt + VW'(1);
            end
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign origin = (h_cnt == '0) && (v_cnt == '0) && !field;
    assign hsync  = (h_cnt >= HS_LO) && (h_cnt < HS_HI);

    // Field 1 vsync edges sit half a line late to give the interlace offset.
    always_comb begin
        if (field) begin
            vsync = ((v_cnt > VS_LO) || ((v_cnt == VS_LO) && (h_cnt >= H_HALF))) &&
                    ((v_cnt < VS_HI) || ((v_cnt == VS_HI) && (h_cnt < H_HALF)));
        end else begin
            vsync = (v_cnt >= VS_LO) && (v_cnt < VS_HI);
        end
    end

`ifdef RS170_TEST_PATTERN_EN
    assign bar = 3'((int'(h_cnt) * 8) / H_ACTIVE);
`endif

endmodule

// File: rtl/rs170_timing_ctrl.sv
// RS170 interlaced timing generator feeding the DDR output stage from an AXI4-Stream
// pixel source. Optional colour-bar source is built in with RS170_TEST_PATTERN_EN.
//
// state       | meaning
// UNLOCKED    | hunting for a start-of-frame beat, non-SOF beats are dropped
// WAIT_ORIGIN | SOF beat held by the source until raster pixel (0,0) of field 0
// LOCKED      | one beat consumed per active pixel
module rs170_timing_ctrl
    import rs170_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 16,
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FP            = DEF_H_FP,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BP            = DEF_H_BP,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FP            = DEF_V_FP,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BP            = DEF_V_BP,
    parameter logic [AXIS_DATA_WIDTH-1:0] BLANK_VALUE = '0
) (
    input  logic                       i_pclk,
    input  logic                       i_rst,
    input  logic                       i_enable,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tuser,
`ifdef RS170_TEST_PATTERN_EN
    input  logic                       i_pattern_sel,
`endif
    output logic                       o_vsync,
    output logic                       o_hsync,
    output logic                       o_blank,
    output logic                       o_field,
    output logic [AXIS_DATA_WIDTH-1:0] o_data,
    output logic                       o_locked,
    output logic                       o_underflow,
    output logic                       o_frame_start
);

    localparam int HW = $clog2(span(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW = $clog2(span(V_ACTIVE, V_FP, V_SYNC, V_BP + 1));

    lock_state_t                state;
    lock_state_t                state_nxt;
    logic                       run;
    logic                       field;
    logic                       active;
    logic                       origin;
    logic                       hsync;
    logic                       vsync;
    logic                       tready;
    logic                       underflow;
    logic [AXIS_DATA_WIDTH-1:0] data_nxt;

`ifdef RS170_TEST_PATTERN_EN
    logic [2:0]                 bar;
    logic [AXIS_DATA_WIDTH-1:0] pattern;

    always_comb begin
        pattern = '0;
        for (int i = 0; i < AXIS_DATA_WIDTH; i++) begin
            pattern[i] = bar[i % 3];
        end
    end
`endif

    rs170_raster_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_raster (
        .clk    (i_pclk),
        .rst    (i_rst),
        .enable (i_enable),
        .field  (field),
        .active (active),
        .origin (origin),
        .hsync  (hsync),
        .vsync  (vsync)
`ifdef RS170_TEST_PATTERN_EN
        ,
        .bar    (bar)
`endif
    );

    assign run = i_enable && !i_rst;

    always_comb begin
        state_nxt = state;
        tready    = 1'b0;
        underflow = 1'b0;
        data_nxt  = BLANK_VALUE;
        if (!run) begin
            state_nxt = UNLOCKED;
`ifdef RS170_TEST_PATTERN_EN
        end else if (i_pattern_sel) begin
            state_nxt = UNLOCKED;
            if (active) begin
                data_nxt = pattern;
            end
`endif
        end else begin
            unique case (state)
                UNLOCKED: begin
                    if (s_axis_tvalid && s_axis_tuser) begin
                        state_nxt = WAIT_ORIGIN;
                    end else begin
                        tready = 1'b1;
                    end
                end
                // The SOF beat is taken on the origin pixel itself so it lands at (0,0).
                WAIT_ORIGIN: begin
                    if (origin && s_axis_tvalid) begin
                        if (s_axis_tuser) begin
                            tready    = 1'b1;
                            data_nxt  = s_axis_tdata;
                            state_nxt = LOCKED;
                        end else begin
                            state_nxt = UNLOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (active) begin
                        if (!s_axis_tvalid) begin
                            tready    = 1'b1;
                            underflow = 1'b1;
                            state_nxt = UNLOCKED;
                        end else if (s_axis_tuser && !origin) begin
                            state_nxt = WAIT_ORIGIN;
                        end else begin
                            tready   = 1'b1;
                            data_nxt = s_axis_tdata;
                        end
                    end
                end
                default: state_nxt = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge i_pclk) begin
        if (!run) begin
            state         <= UNLOCKED;
            o_vsync       <= 1'b0;
            o_hsync       <= 1'b0;
            o_blank       <= 1'b1;
            o_field       <= 1'b0;
            o_data        <= BLANK_VALUE;
            o_underflow   <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            state         <= state_nxt;
            o_vsync       <= vsync;
            o_hsync       <= hsync;
            o_blank       <= !active;
            o_field       <= field;
            o_data        <= data_nxt;
            o_underflow   <= underflow;
            o_frame_start <= origin;
        end
    end

    assign o_locked      = (state == LOCKED);
    assign s_axis_tready = tready;

endmodule
